// File: rtl/bram_arb_pkg.sv
// Shared encodings and defaults for the BRAM port arbiter and its read tracker.
package bram_arb_pkg;

  localparam int NUM_REQ = 2;

  // Requester ids; REQ_NONE is all-zero so a cleared pipeline slot reads as "no owner".
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ0     = 2'd1,
    REQ1     = 2'd2
  } req_id_e;

  localparam logic [3:0] WE_READ = 4'b0000;
  localparam logic [3:0] WE_WORD = 4'b1111;

  localparam int DEF_RD_LAT    = 1;
  localparam int DEF_MAX_BURST = 8;

  localparam logic [7:0] BURST_SAT = 8'd255;

  function automatic req_id_e id_of(input logic sel);
    return sel ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/bram_rd_track.sv
// DEPTH-deep {valid, id} pipeline that follows each issued read to its return cycle.
// Slots that carry no read hold id 0, so a tail id match already implies valid.
module bram_rd_track #(
  parameter int DEPTH = 1,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_vld,
  input  logic [ID_W-1:0] ld_id,
  output logic            tail_vld,
  output logic [ID_W-1:0] tail_id
);

  logic [DEPTH:1]           vld_pipe;
  logic [DEPTH:1][ID_W-1:0] id_pipe;

  // Shift one slot per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= ld_vld;
      id_pipe[1]  <= ld_vld ? ld_id : '0;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign tail_vld = vld_pipe[DEPTH];
  assign tail_id  = id_pipe[DEPTH];

endmodule

// File: rtl/bram_rr_arbiter.sv
// Two-requester round-robin arbiter with a burst cap in front of a single BRAM port.
// Grant and BRAM drive are combinational; read returns are steered by a tracker.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [3:0]        r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [3:0]        r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              R_req,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        W_req,
  output logic [DATA_W-1:0] W_data,
  input  logic [DATA_W-1:0] R_data
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][3:0]        we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] ad;
  logic [NUM_REQ-1:0][DATA_W-1:0] wd;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rvalid;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata;

  req_id_e    owner;
  logic [7:0] burst_cnt;
  logic       last;
  logic       sel;
  logic       any_gnt;
  logic       under_cap;
  logic       tail_vld;
  logic [1:0] tail_id;
  logic [1:0] ld_id;

  // Requests are masked while reset is held so nothing is granted.
  assign req = {r1_req, r0_req} & {NUM_REQ{rst}};
  assign we  = {r1_we, r0_we};
  assign ad  = {r1_addr, r0_addr};
  assign wd  = {r1_wdata, r0_wdata};

  assign under_cap = burst_cnt < 8'(MAX_BURST);

  // Owner keeps the port until it drops or hits the cap with the other waiting.
  always_comb begin
    gnt = '0;
    case (owner)
      REQ0: begin
        if (req[0] && (!req[1] || under_cap)) gnt = 2'b01;
        else if (req[1])                      gnt = 2'b10;
      end
      REQ1: begin
        if (req[1] && (!req[0] || under_cap)) gnt = 2'b10;
        else if (req[0])                      gnt = 2'b01;
      end
      default: begin
        if (&req) gnt = last ? 2'b01 : 2'b10;
        else      gnt = req;
      end
    endcase
  end

  assign sel     = gnt[1];
  assign any_gnt = |gnt;
  assign {r1_gnt, r0_gnt} = gnt;

  assign R_req  = any_gnt && (we[sel] == WE_READ);
  assign W_req  = any_gnt ? we[sel] : '0;
  assign addr   = any_gnt ? ad[sel] : '0;
  assign W_data = any_gnt ? wd[sel] : '0;

  // Track owner, run length and last winner; an idle cycle releases ownership.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= REQ_NONE;
      burst_cnt <= '0;
      last      <= 1'b1;
    end else if (any_gnt) begin
      owner <= id_of(sel);
      last  <= sel;
      if (owner == id_of(sel))
        burst_cnt <= (burst_cnt == BURST_SAT) ? burst_cnt : burst_cnt + 8'd1;
      else
        burst_cnt <= 8'd1;
    end else begin
      owner     <= REQ_NONE;
      burst_cnt <= '0;
    end
  end

  assign ld_id = R_req ? id_of(sel) : REQ_NONE;

  bram_rd_track #(
    .DEPTH (RD_LAT),
    .ID_W  (2)
  ) u_rd_track (
    .clk      (clk),
    .rst      (rst),
    .ld_vld   (R_req),
    .ld_id    (ld_id),
    .tail_vld (tail_vld),
    .tail_id  (tail_id)
  );

  // Steer the returning word to whichever requester issued it.
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_ret
    assign rvalid[n] = tail_vld && (tail_id == id_of(1'(n)));
    assign rdata[n]  = (tail_id == id_of(1'(n))) ? R_data : '0;
  end

  assign {r1_rvalid, r0_rvalid} = rvalid;
  assign r0_rdata = rdata[0];
  assign r1_rdata = rdata[1];

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: two instances (read latency 1 and 3) share one stimulus
// stream; a transaction-level model predicts grants and read returns.
module tb_bram_rr_arbiter;
  import bram_arb_pkg::*;

  localparam int MB = 8;
  localparam int NW = 64;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } ret_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        r0_req, r1_req;
  logic [3:0]  r0_we, r1_we;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;

  logic        g0 [2];
  logic        g1 [2];
  logic        rv0 [2];
  logic        rv1 [2];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic        b_rreq [2];
  logic [3:0]  b_wreq [2];
  logic [31:0] b_addr [2];
  logic [31:0] b_wdata [2];
  logic [31:0] b_rdata [2];

  bram_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_BURST(MB)) u_dut0 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(g0[0]), .r0_rvalid(rv0[0]), .r0_rdata(rd0[0]),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(g1[0]), .r1_rvalid(rv1[0]), .r1_rdata(rd1[0]),
    .R_req(b_rreq[0]), .addr(b_addr[0]), .W_req(b_wreq[0]), .W_data(b_wdata[0]),
    .R_data(b_rdata[0])
  );

  bram_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_BURST(MB)) u_dut1 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(g0[1]), .r0_rvalid(rv0[1]), .r0_rdata(rd0[1]),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(g1[1]), .r1_rvalid(rv1[1]), .r1_rdata(rd1[1]),
    .R_req(b_rreq[1]), .addr(b_addr[1]), .W_req(b_wreq[1]), .W_data(b_wdata[1]),
    .R_data(b_rdata[1])
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
  endfunction

  // BRAM models, one per instance: byte-enabled writes, reads delivered via a latency pipe.
  logic [31:0] mem [2][NW];
  logic [31:0] rpipe [2][4];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NW; i++) mem[k][i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int b = 0; b < 4; b++)
          if (b_wreq[k][b]) mem[k][b_addr[k][7:2]][8*b +: 8] <= b_wdata[k][8*b +: 8];
        rpipe[k][0] <= b_rreq[k] ? mem[k][b_addr[k][7:2]] : 32'h0;
        for (int j = 1; j < 4; j++) rpipe[k][j] <= rpipe[k][j-1];
      end
    end
  end

  assign b_rdata[0] = rpipe[0][0];
  assign b_rdata[1] = rpipe[1][2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: who was served last cycle, how many times in a row, who was served last ever.
  int          prev;
  int          run;
  int          last_srv;
  logic [31:0] smem [NW];
  op_t         q [2][$];
  ret_t        sb [2][$];
  int          tcount;
  int          first_r0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [1:0] rq);
    if (rq == 2'b00) return -1;
    if (rq == 2'b01) return 0;
    if (rq == 2'b10) return 1;
    if (prev >= 0) return (run < MB) ? prev : 1 - prev;
    return 1 - last_srv;
  endfunction

  task automatic push_op(input int k, input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    q[k].push_back(o);
  endtask

  task automatic push_rand(input int k);
    int w, s;
    logic [3:0] we;
    w = $urandom_range(0, NW - 1);
    s = $urandom_range(0, 3);
    we = (s == 0) ? WE_READ : (s == 1) ? WE_WORD : 4'($urandom);
    push_op(k, we, 32'(w) << 2, $urandom);
  endtask

  // One arbitration cycle: drive queue fronts, check grant and BRAM drive, update the model.
  task automatic tick();
    logic [1:0]  rq;
    logic [1:0]  eg;
    logic [68:0] ev;
    int          g, w;
    op_t         o;
    ret_t        e;
    rq[0] = q[0].size() != 0;
    rq[1] = q[1].size() != 0;
    r0_req   = rq[0];
    r0_we    = rq[0] ? q[0][0].we    : 4'($urandom);
    r0_addr  = rq[0] ? q[0][0].addr  : $urandom;
    r0_wdata = rq[0] ? q[0][0].wdata : $urandom;
    r1_req   = rq[1];
    r1_we    = rq[1] ? q[1][0].we    : 4'($urandom);
    r1_addr  = rq[1] ? q[1][0].addr  : $urandom;
    r1_wdata = rq[1] ? q[1][0].wdata : $urandom;
    #2;
    g  = model_grant(rq);
    eg = (g < 0) ? 2'b00 : (g == 0) ? 2'b01 : 2'b10;
    ev = '0;
    if (g >= 0) begin
      o  = q[g][0];
      ev = {(o.we == WE_READ), o.we, o.addr, o.wdata};
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt dut%0d cyc%0d", k, cyc), 96'({g1[k], g0[k]}), 96'(eg));
      chk($sformatf("bram drive dut%0d cyc%0d", k, cyc),
          96'({b_rreq[k], b_wreq[k], b_addr[k], b_wdata[k]}), 96'(ev));
    end
    if (g0[0] && first_r0 < 0) first_r0 = tcount;
    if (g >= 0) begin
      o = q[g].pop_front();
      w = int'(o.addr[7:2]);
      if (o.we == WE_READ) begin
        e.id = g; e.data = smem[w]; e.cyc = cyc;
        sb[0].push_back(e);
        sb[1].push_back(e);
      end else begin
        for (int b = 0; b < 4; b++)
          if (o.we[b]) smem[w][8*b +: 8] = o.wdata[8*b +: 8];
      end
      run      = (g == prev) ? ((run < 255) ? run + 1 : 255) : 1;
      prev     = g;
      last_srv = g;
    end else begin
      prev = -1;
      run  = 0;
    end
    tcount++;
    @(negedge clk);
  endtask

  // Hold reset with both requesters asserting; everything driven must be zero.
  task automatic do_reset(input int n);
    rst = 1'b0;
    q[0].delete(); q[1].delete();
    sb[0].delete(); sb[1].delete();
    prev = -1; run = 0; last_srv = 1;
    r0_req = 1'b1; r0_we = 4'($urandom); r0_addr = $urandom; r0_wdata = $urandom;
    r1_req = 1'b1; r1_we = 4'($urandom); r1_addr = $urandom; r1_wdata = $urandom;
    #2;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset outputs dut%0d", k),
          96'({g1[k], g0[k], b_rreq[k], b_wreq[k], b_addr[k], b_wdata[k]}), 96'(0));
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  // Scoreboard side: pop the oldest expected read whenever an instance returns one.
  task automatic mon(input int k);
    logic [1:0] rv;
    ret_t       e;
    int         lat, id;
    logic [31:0] dat, oth;
    lat = (k == 0) ? 1 : 3;
    rv  = {rv1[k], rv0[k]};
    if (rv == 2'b11) begin
      n_cmp++; n_fail++;
      $display("FAIL rvalid onehot dut%0d cyc%0d: got both, required at most one", k, cyc);
    end else if (rv != 2'b00) begin
      id  = rv[0] ? 0 : 1;
      dat = rv[0] ? rd0[k] : rd1[k];
      oth = rv[0] ? rd1[k] : rd0[k];
      if (sb[k].size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected rvalid dut%0d cyc%0d: id %0d data %h, required none", k, cyc, id, dat);
      end else begin
        e = sb[k].pop_front();
        chk($sformatf("read return {id,data,lat} dut%0d cyc%0d", k, cyc),
            {32'(id), dat, 32'(cyc - e.cyc)}, {32'(e.id), e.data, 32'(lat)});
        chk($sformatf("other rdata zero dut%0d", k), 96'(oth), 96'(0));
      end
    end else begin
      chk($sformatf("idle rdata zero dut%0d cyc%0d", k, cyc), 96'({rd1[k], rd0[k]}), 96'(0));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pct;
    for (int i = 0; i < NW; i++) smem[i] = init_word(i);
    tcount = 0; first_r0 = -1;
    rst = 1'b0;
    r0_req = 1'b0; r0_we = '0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = '0; r1_addr = '0; r1_wdata = '0;
    @(negedge clk);
    do_reset(2);

    // single r0 read of 0x10, r1 idle
    push_op(0, WE_READ, 32'h10, 32'h0);
    repeat (4) tick();

    // both request on the first cycle after reset
    do_reset(1);
    push_op(0, WE_READ, 32'h30, 32'h0);
    push_op(1, WE_READ, 32'h34, 32'h0);
    repeat (4) tick();

    // r1 streams, r0 joins at cycle 3: burst cap hands over at cycle 8
    do_reset(1);
    for (int i = 0; i < 12; i++) push_op(1, WE_READ, 32'(i) << 2, 32'h0);
    tcount = 0; first_r0 = -1;
    repeat (3) tick();
    for (int i = 0; i < 12; i++) push_op(0, WE_READ, 32'(i + 16) << 2, 32'h0);
    repeat (26) tick();
    chk("first r0 grant cycle under burst cap", 96'(first_r0), 96'(8));

    // partial write then read-back of the same word
    push_op(0, 4'b0011, 32'h20, 32'h12345678);
    push_op(0, WE_READ, 32'h20, 32'h0);
    repeat (4) tick();

    // reset lands while an r1 read is in flight; first tie afterwards goes to r0
    do_reset(1);
    push_op(1, WE_READ, 32'h44, 32'h0);
    tick();
    do_reset(2);
    push_op(0, WE_READ, 32'h48, 32'h0);
    push_op(1, WE_READ, 32'h4C, 32'h0);
    repeat (5) tick();

    // alternating single reads to words 0..5
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      push_op(i % 2, WE_READ, 32'(i) << 2, 32'h0);
      tick();
    end
    repeat (5) tick();

    // random traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1);
      pct = (i < 200) ? 40 : 85;
      for (int k = 0; k < 2; k++)
        if (q[k].size() == 0 && $urandom_range(0, 99) < pct) begin
          int n;
          n = (i < 200) ? $urandom_range(1, 3) : $urandom_range(1, 14);
          repeat (n) push_rand(k);
        end
      tick();
    end

    repeat (40) tick();
    chk("all reads returned dut0", 96'(sb[0].size()), 96'(0));
    chk("all reads returned dut1", 96'(sb[1].size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
